cv32e40p_sleep_sequencer: RTL and testbench

//  Sequences low-power entry/exit around the core sleep unit.
//  - Watches core_sleep (WFI sleep) and escalates to a deep-sleep (retention) request to the SoC power manager after an idle delay.
//  - Runs the 4-phase pm_req/pm_ack handshake.
//  - Generates wake_from_sleep_o, which drives the wake_from_sleep_i input of the sleep unit's clock enable.
//  - Runs on the free-running clock, so it stays alive while the core clock is gated.

---
 rtl/cv32e40p_pkg.sv | 15 +
 rtl/cv32e40p_sleep_sequencer_chk.sv | 26 ++
 rtl/cv32e40p_sleep_sequencer.sv | 146 ++++++++++++++
 tb/tb_cv32e40p_sleep_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types for the sleep sequencer.
// Contents:
//   sleep_seq_state_e : FSM state encoding, also exported on state_o
package cv32e40p_pkg;

  typedef enum logic [2:0] {
    SSQ_ACTIVE   = 3'd0,
    SSQ_SLEEP    = 3'd1,
    SSQ_PM_ENTER = 3'd2,
    SSQ_DEEP     = 3'd3,
    SSQ_PM_EXIT  = 3'd4,
    SSQ_SETTLE   = 3'd5
  } sleep_seq_state_e;

endpackage

// File: rtl/cv32e40p_sleep_sequencer_chk.sv
// Protocol checker for the sleep sequencer handshake.
// Ports:
//   clk_ungated_i  free-running clock
//   rst_n          async reset, active low
//   state          sequencer state_o
//   pm_req         sequencer pm_req_o
//   pm_ack         power manager ack
module cv32e40p_sleep_sequencer_chk
  import cv32e40p_pkg::*;
(
  input logic       clk_ungated_i,
  input logic       rst_n,
  input logic [2:0] state,
  input logic       pm_req,
  input logic       pm_ack
);

  // Ack while no request is outstanding is a power-manager protocol error.
  a_ack_when_idle: assert property (@(posedge clk_ungated_i) disable iff (!rst_n)
    ((state == SSQ_ACTIVE) || (state == SSQ_SLEEP)) |-> !pm_ack);

  // A pending request is held until acknowledged.
  a_req_held: assert property (@(posedge clk_ungated_i) disable iff (!rst_n)
    ((state == SSQ_PM_ENTER) && !pm_ack) |=> pm_req);

endmodule

// File: rtl/cv32e40p_sleep_sequencer.sv
// Low-power entry/exit sequencer around the core sleep unit.
// Escalates WFI sleep to a retention request after an idle delay, runs the
// 4-phase pm_req/pm_ack handshake and issues the wake to the sleep unit.
// Clocked by the free-running clock so it keeps running while the core
// clock is gated.
// Ports:
//   clk_ungated_i     free-running clock
//   rst_n             async reset, active low
//   core_sleep_i      core is in WFI sleep (clock gated)
//   irq_pending_i     enabled interrupt pending
//   debug_req_i       external debug request
//   pm_ack_i          power manager ack (retention entered while high)
//   wake_from_sleep_o wake to sleep unit (combinational in SLEEP, registered pulse after SETTLE)
//   pm_req_o          deep-sleep request to power manager
//   deep_sleep_o      high in DEEP
//   state_o           current FSM state
//   deep_cnt_o        completed DEEP entries, saturating
module cv32e40p_sleep_sequencer
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEEP_DLY   = 16,
  parameter int unsigned SETTLE_DLY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_ungated_i,
  input  logic             rst_n,
  input  logic             core_sleep_i,
  input  logic             irq_pending_i,
  input  logic             debug_req_i,
  input  logic             pm_ack_i,
  output logic             wake_from_sleep_o,
  output logic             pm_req_o,
  output logic             deep_sleep_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] deep_cnt_o
);

  localparam int unsigned IDLE_W = (DEEP_DLY > 0) ? $clog2(DEEP_DLY + 1) : 1;
  localparam int unsigned SETL_W = (SETTLE_DLY > 0) ? $clog2(SETTLE_DLY + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DEEP_DLY - 1);
  localparam logic [SETL_W-1:0] SETL_LOAD = SETL_W'(SETTLE_DLY);
  localparam logic              DEEP_EN   = (DEEP_DLY != 0);

  sleep_seq_state_e  state_r;
  logic [IDLE_W-1:0] idle_r;
  logic [SETL_W-1:0] settle_r;
  logic              wake_pend_r;
  logic              wake_pulse_r;
  logic              pm_req_r;
  logic              deep_sleep_r;
  logic [CNT_W-1:0]  deep_cnt_r;
  logic              wake_evt_s;

  assign wake_evt_s = irq_pending_i | debug_req_i;

  // In SLEEP the wake bypasses the flops so the core clock re-enables in the
  // same cycle; the post-retention wake is a registered pulse.
  assign wake_from_sleep_o = wake_pulse_r | ((state_r == SSQ_SLEEP) & wake_evt_s);
  assign pm_req_o          = pm_req_r;
  assign deep_sleep_o      = deep_sleep_r;
  assign state_o           = state_r;
  assign deep_cnt_o        = deep_cnt_r;

  // Sequencer FSM with its counters and registered outputs.
  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= SSQ_ACTIVE;
      idle_r       <= '0;
      settle_r     <= '0;
      wake_pend_r  <= 1'b0;
      wake_pulse_r <= 1'b0;
      pm_req_r     <= 1'b0;
      deep_sleep_r <= 1'b0;
      deep_cnt_r   <= '0;
    end else begin
      wake_pulse_r <= 1'b0;
      case (state_r)
        SSQ_ACTIVE: begin
          if (core_sleep_i) begin
            state_r <= SSQ_SLEEP;
            idle_r  <= '0;
          end
        end
        SSQ_SLEEP: begin
          // Wake beats idle expiry when both land in the same cycle.
          if (wake_evt_s || !core_sleep_i) begin
            state_r <= SSQ_ACTIVE;
          end else if (DEEP_EN && (idle_r == IDLE_LAST)) begin
            state_r     <= SSQ_PM_ENTER;
            pm_req_r    <= 1'b1;
            wake_pend_r <= 1'b0;
          end else begin
            idle_r <= idle_r + IDLE_W'(1);
          end
        end
        SSQ_PM_ENTER: begin
          // The request cannot be withdrawn before ack; remember any wake.
          if (wake_evt_s) begin
            wake_pend_r <= 1'b1;
          end
          if (pm_ack_i) begin
            if (wake_pend_r || wake_evt_s) begin
              state_r  <= SSQ_PM_EXIT;
              pm_req_r <= 1'b0;
            end else begin
              state_r      <= SSQ_DEEP;
              deep_sleep_r <= 1'b1;
              if (deep_cnt_r != {CNT_W{1'b1}}) begin
                deep_cnt_r <= deep_cnt_r + CNT_W'(1);
              end
            end
          end
        end
        SSQ_DEEP: begin
          if (wake_evt_s) begin
            state_r      <= SSQ_PM_EXIT;
            pm_req_r     <= 1'b0;
            deep_sleep_r <= 1'b0;
          end
        end
        SSQ_PM_EXIT: begin
          if (!pm_ack_i) begin
            state_r  <= SSQ_SETTLE;
            settle_r <= SETL_LOAD;
          end
        end
        SSQ_SETTLE: begin
          // Wake is issued even if the original wake event has gone away.
          if (settle_r == '0) begin
            state_r      <= SSQ_ACTIVE;
            wake_pulse_r <= 1'b1;
            wake_pend_r  <= 1'b0;
          end else begin
            settle_r <= settle_r - SETL_W'(1);
          end
        end
        default: begin
          state_r      <= SSQ_ACTIVE;
          pm_req_r     <= 1'b0;
          deep_sleep_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_sleep_sequencer.sv
// Directed bench for cv32e40p_sleep_sequencer: main instance (16/4/16),
// a deep-sleep-disabled instance and a 2-bit-counter instance.
module tb_cv32e40p_sleep_sequencer;
  import cv32e40p_pkg::*;

  logic clk;
  logic rst_n;
  logic sleep, irq, dbg, ack;
  logic m_wake, m_req, m_deep;
  logic [2:0] m_state;
  logic [15:0] m_cnt;
  logic nd_sleep;
  logic nd_wake, nd_req, nd_deep;
  logic [2:0] nd_state;
  logic [15:0] nd_cnt;
  logic s_sleep, s_irq, s_ack;
  logic s_wake, s_req, s_deep;
  logic [2:0] s_state;
  logic [1:0] s_cnt;
  logic seen;
  int total;
  int bad;

  cv32e40p_sleep_sequencer #(.DEEP_DLY(16), .SETTLE_DLY(4), .CNT_W(16)) dut (
    .clk_ungated_i(clk), .rst_n(rst_n), .core_sleep_i(sleep), .irq_pending_i(irq),
    .debug_req_i(dbg), .pm_ack_i(ack), .wake_from_sleep_o(m_wake), .pm_req_o(m_req),
    .deep_sleep_o(m_deep), .state_o(m_state), .deep_cnt_o(m_cnt));

  cv32e40p_sleep_sequencer_chk chk_main (
    .clk_ungated_i(clk), .rst_n(rst_n), .state(m_state), .pm_req(m_req), .pm_ack(ack));

  cv32e40p_sleep_sequencer #(.DEEP_DLY(0), .SETTLE_DLY(4), .CNT_W(16)) dut_nd (
    .clk_ungated_i(clk), .rst_n(rst_n), .core_sleep_i(nd_sleep), .irq_pending_i(1'b0),
    .debug_req_i(1'b0), .pm_ack_i(1'b0), .wake_from_sleep_o(nd_wake), .pm_req_o(nd_req),
    .deep_sleep_o(nd_deep), .state_o(nd_state), .deep_cnt_o(nd_cnt));

  cv32e40p_sleep_sequencer #(.DEEP_DLY(2), .SETTLE_DLY(1), .CNT_W(2)) dut_sat (
    .clk_ungated_i(clk), .rst_n(rst_n), .core_sleep_i(s_sleep), .irq_pending_i(s_irq),
    .debug_req_i(1'b0), .pm_ack_i(s_ack), .wake_from_sleep_o(s_wake), .pm_req_o(s_req),
    .deep_sleep_o(s_deep), .state_o(s_state), .deep_cnt_o(s_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    sleep = 1'b0; irq = 1'b0; dbg = 1'b0; ack = 1'b0;
    nd_sleep = 1'b0; s_sleep = 1'b0; s_irq = 1'b0; s_ack = 1'b0;
    seen = 1'b0;
    tick(3);
    chk("rst_state", m_state, SSQ_ACTIVE);
    chk("rst_req", m_req, 0);
    chk("rst_wake", m_wake, 0);
    chk("rst_deep", m_deep, 0);
    chk("rst_cnt", m_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    tick(1);

    // 1: shallow sleep, irq wakes in the same cycle
    sleep = 1'b1;
    tick(1);
    chk("t1_sleep", m_state, SSQ_SLEEP);
    tick(4);
    irq = 1'b1;
    #1;
    chk("t1_wake_comb", m_wake, 1);
    tick(1);
    chk("t1_active", m_state, SSQ_ACTIVE);
    chk("t1_req", m_req, 0);
    chk("t1_wake_active", m_wake, 0);
    sleep = 1'b0; irq = 1'b0;
    tick(1);

    // 2: idle escalation to DEEP
    sleep = 1'b1;
    tick(1);
    tick(15);
    chk("t2_req_lo", m_req, 0);
    chk("t2_still_sleep", m_state, SSQ_SLEEP);
    tick(1);
    chk("t2_req_hi", m_req, 1);
    chk("t2_pm_enter", m_state, SSQ_PM_ENTER);
    ack = 1'b1;
    tick(1);
    chk("t2_deep", m_deep, 1);
    chk("t2_cnt", m_cnt, 1);
    chk("t2_req_deep", m_req, 1);
    sleep = 1'b0;
    tick(1);
    chk("t2_sleep_drop_ign", m_state, SSQ_DEEP);

    // 3: debug wake from DEEP, settle timing
    dbg = 1'b1;
    tick(1);
    chk("t3_req_lo", m_req, 0);
    chk("t3_pm_exit", m_state, SSQ_PM_EXIT);
    chk("t3_deep_lo", m_deep, 0);
    dbg = 1'b0;
    tick(2);
    chk("t3_wait_ack", m_state, SSQ_PM_EXIT);
    ack = 1'b0;
    tick(5);
    chk("t3_no_wake_yet", m_wake, 0);
    chk("t3_settle", m_state, SSQ_SETTLE);
    tick(1);
    chk("t3_wake", m_wake, 1);
    chk("t3_active", m_state, SSQ_ACTIVE);
    tick(1);
    chk("t3_wake_width", m_wake, 0);

    // 4: wake during PM_ENTER skips DEEP
    sleep = 1'b1;
    tick(17);
    chk("t4_pm_enter", m_state, SSQ_PM_ENTER);
    irq = 1'b1;
    tick(1);
    irq = 1'b0;
    chk("t4_hold_state", m_state, SSQ_PM_ENTER);
    tick(4);
    chk("t4_req_held", m_req, 1);
    chk("t4_hold_state2", m_state, SSQ_PM_ENTER);
    ack = 1'b1;
    tick(1);
    chk("t4_pm_exit", m_state, SSQ_PM_EXIT);
    chk("t4_no_deep", m_deep, 0);
    chk("t4_req_lo", m_req, 0);
    ack = 1'b0; sleep = 1'b0;
    tick(6);
    chk("t4_wake", m_wake, 1);
    chk("t4_cnt_same", m_cnt, 1);
    tick(1);

    // 5a: wake and idle expiry coincide
    sleep = 1'b1;
    tick(16);
    chk("t5_sleep_last", m_state, SSQ_SLEEP);
    irq = 1'b1;
    #1;
    chk("t5_wake", m_wake, 1);
    tick(1);
    chk("t5_active", m_state, SSQ_ACTIVE);
    chk("t5_req", m_req, 0);
    irq = 1'b0; sleep = 1'b0;
    tick(1);
    chk("t5_req2", m_req, 0);

    // 5b: sleep dropped without wake event
    sleep = 1'b1;
    tick(1);
    sleep = 1'b0;
    #1;
    chk("t5b_no_wake", m_wake, 0);
    tick(1);
    chk("t5b_active", m_state, SSQ_ACTIVE);

    // 5c: DEEP_DLY=0 never requests
    nd_sleep = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      seen = seen | nd_req | nd_deep;
    end
    chk("t5c_no_req", seen, 0);
    chk("t5c_state", nd_state, SSQ_SLEEP);
    chk("t5c_wake", nd_wake, 0);
    chk("t5c_cnt", nd_cnt, 0);
    nd_sleep = 1'b0;

    // 6a: deep_cnt saturation with CNT_W=2
    for (int it = 1; it <= 5; it++) begin
      s_sleep = 1'b1;
      tick(3);
      chk("t6_sat_pm_enter", s_state, SSQ_PM_ENTER);
      s_ack = 1'b1;
      tick(1);
      chk("t6_sat_cnt", s_cnt, (it < 3) ? it : 3);
      chk("t6_sat_deep", s_deep & s_req, 1);
      s_irq = 1'b1;
      tick(1);
      s_irq = 1'b0; s_ack = 1'b0; s_sleep = 1'b0;
      tick(2);
      tick(1);
      chk("t6_sat_wake", s_wake, 1);
      tick(1);
    end

    // 6b: reset asserted in DEEP
    sleep = 1'b1;
    tick(17);
    ack = 1'b1;
    tick(1);
    chk("t6_in_deep", m_state, SSQ_DEEP);
    chk("t6_cnt2", m_cnt, 2);
    #2;
    rst_n = 1'b0; ack = 1'b0; sleep = 1'b0;
    #1;
    chk("t6_req_async", m_req, 0);
    chk("t6_deep_async", m_deep, 0);
    chk("t6_wake_async", m_wake, 0);
    chk("t6_state_async", m_state, SSQ_ACTIVE);
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    chk("t6_cnt_cleared", m_cnt, 0);
    chk("t6_state_after", m_state, SSQ_ACTIVE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
